// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } rx_state_e;

    // data_bits encoding: number of data bits = code + MIN_DATA_BITS
    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_rx_frame_fsm.sv
// UART RX framing FSM: start detection, mid-bit sampling on oversample ticks,
// 5-8 data bits, optional parity, 1 or 2 stop bits, per-frame status pulses.
module uart_rx_frame_fsm
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rx_filtered,
    input  logic [1:0] data_bits,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       stop_two,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_active,
    output logic       bit_valid,
    output logic       frame_error,
    output logic       parity_error
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] START_LIMIT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LIMIT   = CNT_W'(OVERSAMPLE - 1);

    rx_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             armed_reg, armed_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             par_acc_reg, par_acc_next;
    logic             par_err_reg, par_err_next;
    logic             frm_err_reg, frm_err_next;
    logic [1:0]       cfg_bits_reg, cfg_bits_next;
    logic             cfg_par_en_reg, cfg_par_en_next;
    logic             cfg_odd_reg, cfg_odd_next;
    logic             cfg_stop_two_reg, cfg_stop_two_next;

    logic [7:0]       rx_data_reg, rx_data_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             bit_valid_reg, bit_valid_next;
    logic             frame_error_reg, frame_error_next;
    logic             parity_error_reg, parity_error_next;
    logic             frame_active_reg;

    logic [CNT_W-1:0] limit;
    logic             at_limit;
    logic [2:0]       last_bit;

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        armed_next        = armed_reg;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        par_acc_next      = par_acc_reg;
        par_err_next      = par_err_reg;
        frm_err_next      = frm_err_reg;
        cfg_bits_next     = cfg_bits_reg;
        cfg_par_en_next   = cfg_par_en_reg;
        cfg_odd_next      = cfg_odd_reg;
        cfg_stop_two_next = cfg_stop_two_reg;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        bit_valid_next    = 1'b0;
        frame_error_next  = 1'b0;
        parity_error_next = 1'b0;

        limit    = (state_reg == START) ? START_LIMIT : BIT_LIMIT;
        at_limit = (cnt_reg == limit);
        last_bit = {1'b0, cfg_bits_reg} + 3'(MIN_DATA_BITS - 1);

        if (sample_tick) begin
            if (state_reg == IDLE) begin
                // A falling edge only counts once the line has been seen high,
                // so a held-low (break) line never retriggers.
                if (armed_reg && !rx_filtered) begin
                    state_next        = START;
                    cnt_next          = '0;
                    armed_next        = 1'b0;
                    bit_cnt_next      = '0;
                    shift_next        = '0;
                    par_acc_next      = 1'b0;
                    par_err_next      = 1'b0;
                    frm_err_next      = 1'b0;
                    cfg_bits_next     = data_bits;
                    cfg_par_en_next   = parity_en;
                    cfg_odd_next      = parity_odd;
                    cfg_stop_two_next = stop_two;
                end else if (rx_filtered) begin
                    armed_next = 1'b1;
                end
            end else if (!at_limit) begin
                cnt_next = cnt_reg + 1'b1;
            end else begin
                cnt_next       = '0;
                bit_valid_next = 1'b1;
                case (state_reg)
                    START: begin
                        if (rx_filtered) begin
                            state_next     = IDLE;
                            bit_valid_next = 1'b0;
                        end else begin
                            state_next = DATA;
                        end
                    end
                    DATA: begin
                        shift_next   = {rx_filtered, shift_reg[7:1]};
                        par_acc_next = par_acc_reg ^ rx_filtered;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == last_bit)
                            state_next = cfg_par_en_reg ? PARITY : STOP1;
                    end
                    PARITY: begin
                        par_err_next = ((par_acc_reg ^ rx_filtered) != cfg_odd_reg);
                        state_next   = STOP1;
                    end
                    STOP1, STOP2: begin
                        if (state_reg == STOP1 && cfg_stop_two_reg) begin
                            frm_err_next = frm_err_reg | ~rx_filtered;
                            state_next   = STOP2;
                        end else begin
                            // Shifted in from the top; right-justify the N bits.
                            rx_data_next      = shift_reg >> (DATA_BITS_8 - cfg_bits_reg);
                            rx_valid_next     = 1'b1;
                            frame_error_next  = frm_err_reg | ~rx_filtered;
                            parity_error_next = par_err_reg;
                            state_next        = IDLE;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            armed_reg        <= 1'b0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            par_acc_reg      <= 1'b0;
            par_err_reg      <= 1'b0;
            frm_err_reg      <= 1'b0;
            cfg_bits_reg     <= DATA_BITS_8;
            cfg_par_en_reg   <= 1'b0;
            cfg_odd_reg      <= 1'b0;
            cfg_stop_two_reg <= 1'b0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            bit_valid_reg    <= 1'b0;
            frame_error_reg  <= 1'b0;
            parity_error_reg <= 1'b0;
            frame_active_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            armed_reg        <= armed_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            par_acc_reg      <= par_acc_next;
            par_err_reg      <= par_err_next;
            frm_err_reg      <= frm_err_next;
            cfg_bits_reg     <= cfg_bits_next;
            cfg_par_en_reg   <= cfg_par_en_next;
            cfg_odd_reg      <= cfg_odd_next;
            cfg_stop_two_reg <= cfg_stop_two_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            bit_valid_reg    <= bit_valid_next;
            frame_error_reg  <= frame_error_next;
            parity_error_reg <= parity_error_next;
            frame_active_reg <= (state_next != IDLE);
        end
    end

    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign bit_valid    = bit_valid_reg;
    assign frame_error  = frame_error_reg;
    assign parity_error = parity_error_reg;
    assign frame_active = frame_active_reg;

endmodule
